// File: rtl/bf_io_pkg.sv
// Shared types and constants for the brainfuckCore character output path.
package bf_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic UART_START_BIT = 1'b0;
  localparam logic UART_STOP_BIT  = 1'b1;
  localparam int   UART_DATA_BITS = 8;

endpackage

// File: rtl/bf_char_fifo.sv
// Small synchronous character FIFO. A push while full is accepted only
// when a pop happens on the same edge, so the slot being freed is reused.
module bf_char_fifo
  import bf_io_pkg::*;
#(
  parameter int AW = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [UART_DATA_BITS-1:0] din,
  input  logic                      pop,
  output logic [UART_DATA_BITS-1:0] dout,
  output logic                      full,
  output logic                      empty,
  output logic [AW:0]               level
);

  localparam int DEPTH = 1 << AW;

  logic [UART_DATA_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]             wr_ptr;
  logic [AW-1:0]             rd_ptr;
  logic [AW:0]               count;
  logic                      do_push;
  logic                      do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];
  assign level   = count;

  // Storage array; no reset needed since count gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; reset flushes the queue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bf_char_tx.sv
// UART transmitter for brainfuckCore output characters, 8N1, LSB first,
// with a FIFO absorbing bursts from the core. Defining BF_CHAR_TX_PARITY_EN
// inserts an even-parity bit between the data bits and the stop bit.
module bf_char_tx
  import bf_io_pkg::*;
#(
  parameter int CLK_PER_BIT = 16,
  parameter int FIFO_AW     = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sendingChar,
  input  logic [UART_DATA_BITS-1:0] sendedChar,
  output logic                      tx,
  output logic                      busy,
  output logic                      overflow,
  output logic [FIFO_AW:0]          fifo_level
);

  localparam int TW = $clog2(CLK_PER_BIT);
  localparam logic [TW-1:0] BIT_LAST = TW'(CLK_PER_BIT - 1);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  tx_state_t                 state, state_n;
  logic [TW-1:0]             timer, timer_n;
  logic [2:0]                idx, idx_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic                      tx_q, tx_n;
  logic                      overflow_q;
  logic                      start_frame;
  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [UART_DATA_BITS-1:0] fifo_dout;
`ifdef BF_CHAR_TX_PARITY_EN
  logic                      parity_q, parity_n;
`endif

  bf_char_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (sendingChar),
    .din   (sendedChar),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Next-state logic: bit timing, data shifting and frame chaining.
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    idx_n       = idx;
    shreg_n     = shreg;
    tx_n        = tx_q;
    start_frame = 1'b0;
`ifdef BF_CHAR_TX_PARITY_EN
    parity_n    = parity_q;
`endif
    case (state)
      IDLE: begin
        if (!fifo_empty) start_frame = 1'b1;
      end
      START: begin
        if (timer == '0) begin
          state_n = DATA;
          idx_n   = '0;
          timer_n = BIT_LAST;
          tx_n    = shreg[0];
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      DATA: begin
        if (timer == '0) begin
          timer_n = BIT_LAST;
          if (idx == IDX_LAST) begin
`ifdef BF_CHAR_TX_PARITY_EN
            state_n = PARITY;
            tx_n    = parity_q;
`else
            state_n = STOP;
            tx_n    = UART_STOP_BIT;
`endif
          end else begin
            idx_n   = idx + 1'b1;
            shreg_n = shreg >> 1;
            tx_n    = shreg[1];
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end
`ifdef BF_CHAR_TX_PARITY_EN
      PARITY: begin
        if (timer == '0) begin
          state_n = STOP;
          timer_n = BIT_LAST;
          tx_n    = UART_STOP_BIT;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
`endif
      STOP: begin
        if (timer == '0) begin
          if (!fifo_empty) start_frame = 1'b1;
          else             state_n = IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = UART_STOP_BIT;
      end
    endcase
    if (start_frame) begin
      state_n = START;
      timer_n = BIT_LAST;
      shreg_n = fifo_dout;
      tx_n    = UART_START_BIT;
`ifdef BF_CHAR_TX_PARITY_EN
      parity_n = ^fifo_dout;
`endif
    end
  end

  assign fifo_pop = start_frame;

  // FSM and datapath registers; reset abandons any frame and idles the line.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      timer    <= '0;
      idx      <= '0;
      shreg    <= '0;
      tx_q     <= UART_STOP_BIT;
`ifdef BF_CHAR_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      idx      <= idx_n;
      shreg    <= shreg_n;
      tx_q     <= tx_n;
`ifdef BF_CHAR_TX_PARITY_EN
      parity_q <= parity_n;
`endif
    end
  end

  // Sticky drop flag: a push into a full FIFO with no pop frees no slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (sendingChar && fifo_full && !fifo_pop) begin
      overflow_q <= 1'b1;
    end
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign busy     = (state != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_bf_char_tx.sv
// Scoreboard bench for bf_char_tx: stimulus queues expected characters,
// a UART-decoding monitor pops and compares each received frame.
module tb_bf_char_tx;

  localparam int CPB = 4;
  localparam int AW  = 3;
`ifdef BF_CHAR_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic          clk;
  logic          reset;
  logic          sendingChar;
  logic [7:0]    sendedChar;
  logic          tx;
  logic          busy;
  logic          overflow;
  logic [AW:0]   fifo_level;

  int            vectors     = 0;
  int            miscompares = 0;
  int            cycle       = 0;
  logic [7:0]    sb[$];
  int            start_times[$];
  logic          par_seen[$];
  bit            mon_busy    = 1'b0;

  bf_char_tx #(.CLK_PER_BIT(CPB), .FIFO_AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .sendingChar (sendingChar),
    .sendedChar  (sendedChar),
    .tx          (tx),
    .busy        (busy),
    .overflow    (overflow),
    .fifo_level  (fifo_level)
  );

  // Free-running clock and cycle counter used for frame spacing.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  // Safety net so the run always terminates.
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Called at posedge+#1; the push is sampled on the following edge.
  task automatic applyStimulus(input logic [7:0] c, input bit accept);
    sendingChar = 1'b1;
    sendedChar  = c;
    if (accept) sb.push_back(c);
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy || mon_busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain_in_time", 32'(n < budget), 32'd1);
  endtask

  task automatic watchIdle(input string name, input int n);
    int lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    checkOutput(name, lows, 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: decode each UART frame mid-bit and compare with the scoreboard.
  initial begin : monitor
    logic [FRAME_BITS-1:0] bits;
    logic [7:0]            exp_c;
    bit                    ok;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && tx === 1'b0) begin
        mon_busy = 1'b1;
        ok       = 1'b1;
        bits     = '1;
        start_times.push_back(cycle);
        for (int off = 1; off < FRAME; off++) begin
          @(negedge clk);
          if (reset !== 1'b1) begin
            ok = 1'b0;
            break;
          end
          if (off % CPB == CPB / 2) bits[off / CPB] = tx;
        end
        if (ok) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL frame_unexpected: got 0x%0h, want no frame", bits[8:1]);
          end else begin
            exp_c = sb.pop_front();
            checkOutput("frame_data", 32'(bits[8:1]), 32'(exp_c));
            checkOutput("frame_start_bit", 32'(bits[0]), 32'd0);
            checkOutput("frame_stop_bit", 32'(bits[FRAME_BITS-1]), 32'd1);
`ifdef BF_CHAR_TX_PARITY_EN
            checkOutput("frame_parity", 32'(bits[9]), 32'(^exp_c));
            par_seen.push_back(bits[9]);
`endif
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  // Directed stimulus sequence.
  initial begin
    reset       = 1'b0;
    sendingChar = 1'b0;
    sendedChar  = 8'h00;

    // Reset held for 5 cycles, then a quiet line.
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    checkOutput("reset_level", 32'(fifo_level), 32'd0);
    watchIdle("reset_idle_tx_lows", 50);

    // Single 'A': tx falls one edge after the push, busy drops a frame later.
    applyStimulus(8'h41, 1'b1);
    sendingChar = 1'b0;
    checkOutput("single_level_after_push", 32'(fifo_level), 32'd1);
    checkOutput("single_busy_after_push", 32'(busy), 32'd1);
    checkOutput("single_tx_before_pop", 32'(tx), 32'd1);
    waitCycles(1);
    checkOutput("single_tx_fell", 32'(tx), 32'd0);
    checkOutput("single_level_after_pop", 32'(fifo_level), 32'd0);
    waitCycles(FRAME - 1);
    checkOutput("single_busy_last_cycle", 32'(busy), 32'd1);
    checkOutput("single_stop_level", 32'(tx), 32'd1);
    waitCycles(1);
    checkOutput("single_busy_dropped", 32'(busy), 32'd0);
    waitDrain(200);

    // Three back-to-back characters: contiguous frames, level peaks at 2.
    start_times.delete();
    applyStimulus(8'h48, 1'b1);
    applyStimulus(8'h69, 1'b1);
    applyStimulus(8'h0A, 1'b1);
    sendingChar = 1'b0;
    checkOutput("burst3_level_peak", 32'(fifo_level), 32'd2);
    waitDrain(600);
    checkOutput("burst3_frame_count", start_times.size(), 3);
    if (start_times.size() == 3) begin
      checkOutput("burst3_gap_1", start_times[1] - start_times[0], FRAME);
      checkOutput("burst3_gap_2", start_times[2] - start_times[1], FRAME);
    end

    // Ten pushes: FIFO fills to 8, the tenth is dropped.
    start_times.delete();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h30 + 8'(i), i < 9);
      if (i == 8) begin
        checkOutput("fill_level_full", 32'(fifo_level), 32'd8);
        checkOutput("fill_no_overflow_yet", 32'(overflow), 32'd0);
      end
      if (i == 9) begin
        checkOutput("fill_overflow_set", 32'(overflow), 32'd1);
        checkOutput("fill_level_after_drop", 32'(fifo_level), 32'd8);
      end
    end
    sendingChar = 1'b0;
    waitDrain(2000);
    checkOutput("fill_frame_count", start_times.size(), 9);
    checkOutput("fill_overflow_sticky", 32'(overflow), 32'd1);

`ifdef BF_CHAR_TX_PARITY_EN
    // Parity: 0x41 has even weight (bit 0), 0x43 odd weight (bit 1).
    start_times.delete();
    par_seen.delete();
    applyStimulus(8'h41, 1'b1);
    applyStimulus(8'h43, 1'b1);
    sendingChar = 1'b0;
    waitDrain(600);
    checkOutput("parity_frame_count", par_seen.size(), 2);
    if (par_seen.size() == 2) begin
      checkOutput("parity_0x41", 32'(par_seen[0]), 32'd0);
      checkOutput("parity_0x43", 32'(par_seen[1]), 32'd1);
    end
    if (start_times.size() == 2) begin
      checkOutput("parity_frame_len", start_times[1] - start_times[0], 44);
    end
`endif

    // Reset during DATA bit 3 with two characters queued.
    applyStimulus(8'h41, 1'b1);
    applyStimulus(8'h42, 1'b1);
    applyStimulus(8'h43, 1'b1);
    sendingChar = 1'b0;
    checkOutput("midreset_queued", 32'(fifo_level), 32'd2);
    waitCycles(16);
    checkOutput("midreset_bit3_value", 32'(tx), 32'd0);
    reset = 1'b0;
    #1;
    sb.delete();
    checkOutput("midreset_tx_high", 32'(tx), 32'd1);
    checkOutput("midreset_level_flushed", 32'(fifo_level), 32'd0);
    checkOutput("midreset_busy_low", 32'(busy), 32'd0);
    checkOutput("midreset_overflow_cleared", 32'(overflow), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    watchIdle("midreset_idle_tx_lows", 60);
    checkOutput("midreset_busy_after", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
